// File: rtl/lcr580_io_pkg.sv
// Shared definitions for LCR580 port-mapped I/O peripherals: register
// offsets, control bit positions and the idle read value of the port bus.
package lcr580_io_pkg;

  localparam logic [15:0] REG_PEND  = 16'd0;
  localparam logic [15:0] REG_MASK  = 16'd1;
  localparam logic [15:0] REG_ISR   = 16'd2;
  localparam logic [15:0] REG_RAISE = 16'd3;
  localparam logic [15:0] REG_CTRL  = 16'd4;

  localparam int CTRL_ROT  = 0;
  localparam int CTRL_AEOI = 1;

  localparam logic [7:0] IO_READ_IDLE = 8'hFF;

  // Index width for an n-entry channel set; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Rotating priority encoder: returns the first set request found when
// scanning upward from start and wrapping modulo NCHAN.
module irq_prio_enc
  import lcr580_io_pkg::*;
#(
  parameter int NCHAN = 3,
  localparam int IW = idx_width(NCHAN)
) (
  input  logic [NCHAN-1:0] req,
  input  logic [IW-1:0]    start,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;

  // Scan candidates start, start+1, ... (mod NCHAN) and keep the first hit.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    sum_s  = '0;
    cand_s = '0;
    for (int k = 0; k < NCHAN; k++) begin
      sum_s = {1'b0, start} + (IW+1)'(k);
      if (sum_s >= (IW+1)'(NCHAN)) begin
        cand_s = IW'(sum_s - (IW+1)'(NCHAN));
      end else begin
        cand_s = IW'(sum_s);
      end
      if (!valid && req[cand_s]) begin
        valid = 1'b1;
        idx   = cand_s;
      end else begin
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Port-mapped interrupt controller: latches request pulses, masks, arbitrates
// (fixed or rotating) and signals the CPU by toggling irq with a 4-bit vector.
module irq_ctrl
  import lcr580_io_pkg::*;
#(
  parameter int          NCHAN    = 3,
  parameter logic [15:0] BASE     = 16'h00F0,
  parameter logic [3:0]  VBASE    = 4'd1,
  parameter logic [7:0]  RST_PEND = 8'h01
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [15:0]      address,
  input  logic [7:0]       out,
  input  logic             port_rd,
  input  logic             port_we,
  input  logic [NCHAN-1:0] src,
  input  logic             iff1,
  output logic             irq,
  output logic [3:0]       vect,
  output logic [7:0]       pin
);

  localparam int IW = idx_width(NCHAN);

  localparam logic [15:0] A_PEND  = BASE + REG_PEND;
  localparam logic [15:0] A_MASK  = BASE + REG_MASK;
  localparam logic [15:0] A_ISR   = BASE + REG_ISR;
  localparam logic [15:0] A_RAISE = BASE + REG_RAISE;
  localparam logic [15:0] A_CTRL  = BASE + REG_CTRL;

  logic [NCHAN-1:0] pend_r, mask_r, isr_r;
  logic [1:0]       ctrl_r;
  logic [IW-1:0]    ptr_r;
  logic             irq_r;
  logic [3:0]       vect_r;

  logic [NCHAN-1:0] wdata_s, elig_s, win_oh_s, set_s, clr_s;
  logic [NCHAN-1:0] pend_nxt_s, isr_nxt_s;
  logic [IW-1:0]    start_s, win_idx_s, ptr_nxt_s;
  logic             win_vld_s, dispatch_s, rot_s, aeoi_s;
  logic             wr_pend_s, wr_mask_s, wr_isr_s, wr_raise_s, wr_ctrl_s;
  logic             unused_s;

  assign wdata_s    = out[NCHAN-1:0];
  assign rot_s      = ctrl_r[CTRL_ROT];
  assign aeoi_s     = ctrl_r[CTRL_AEOI];
  assign wr_pend_s  = port_we && (address == A_PEND);
  assign wr_mask_s  = port_we && (address == A_MASK);
  assign wr_isr_s   = port_we && (address == A_ISR);
  assign wr_raise_s = port_we && (address == A_RAISE);
  assign wr_ctrl_s  = port_we && (address == A_CTRL);
  assign elig_s     = pend_r & mask_r;
  assign start_s    = rot_s ? ptr_r : '0;
  assign unused_s   = ^{port_rd, out};

  irq_prio_enc #(.NCHAN(NCHAN)) u_prio_enc (
    .req   (elig_s),
    .start (start_s),
    .valid (win_vld_s),
    .idx   (win_idx_s)
  );

  // Dispatch decision and next-state of the request/in-service bookkeeping.
  // Sets are OR-ed after clears so a same-cycle event is never lost, and the
  // EOI clear is applied before the new in-service bit is added.
  always_comb begin
    dispatch_s = 1'b0;
    win_oh_s   = '0;
    set_s      = src;
    clr_s      = '0;
    isr_nxt_s  = isr_r;
    ptr_nxt_s  = ptr_r;
    if (iff1 && win_vld_s && ((isr_r == '0) || aeoi_s)) begin
      dispatch_s = 1'b1;
      win_oh_s   = NCHAN'(1) << win_idx_s;
    end else begin
      dispatch_s = 1'b0;
    end
    if (wr_raise_s) begin
      set_s = src | wdata_s;
    end else begin
      set_s = src;
    end
    if (wr_pend_s) begin
      clr_s = win_oh_s | wdata_s;
    end else begin
      clr_s = win_oh_s;
    end
    if (wr_isr_s) begin
      isr_nxt_s = '0;
    end else begin
      isr_nxt_s = isr_r;
    end
    if (dispatch_s && !aeoi_s) begin
      isr_nxt_s = isr_nxt_s | win_oh_s;
    end else begin
      isr_nxt_s = isr_nxt_s;
    end
    if (dispatch_s && rot_s) begin
      if (win_idx_s == IW'(NCHAN-1)) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = win_idx_s + IW'(1);
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
    pend_nxt_s = (pend_r & ~clr_s) | set_s;
  end

  // Controller state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_r <= RST_PEND[NCHAN-1:0];
      mask_r <= '1;
      isr_r  <= '0;
      ctrl_r <= 2'b00;
      ptr_r  <= '0;
      irq_r  <= 1'b0;
      vect_r <= 4'd0;
    end else begin
      pend_r <= pend_nxt_s;
      isr_r  <= isr_nxt_s;
      ptr_r  <= ptr_nxt_s;
      if (wr_mask_s) begin
        mask_r <= wdata_s;
      end
      if (wr_ctrl_s) begin
        ctrl_r <= out[1:0];
      end
      if (dispatch_s) begin
        irq_r  <= ~irq_r;
        vect_r <= VBASE + 4'(win_idx_s);
      end
    end
  end

  assign irq  = irq_r;
  assign vect = vect_r;

  // Side-effect-free register readback on a full 16-bit address match.
  always_comb begin
    pin = IO_READ_IDLE;
    case (address)
      A_PEND:  pin = 8'(pend_r);
      A_MASK:  pin = 8'(mask_r);
      A_ISR:   pin = 8'(isr_r);
      A_RAISE: pin = 8'h00;
      A_CTRL:  pin = {6'b000000, ctrl_r};
      default: pin = IO_READ_IDLE;
    endcase
  end

endmodule
